// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA raster timing slice.
// Defaults describe 640x480@60 with a 25.175 MHz pixel clock.
package vga_pkg;

    localparam int unsigned COORD_W   = 10;
    localparam int unsigned MAX_TOTAL = 1024;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FRONT  = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BACK   = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FRONT  = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BACK   = 33;
    localparam int unsigned DEF_PIPE     = 2;
    localparam int unsigned MAX_PIPE     = 7;

    typedef enum logic [1:0] {
        ACTIVE,
        FRONT,
        SYNC,
        BACK
    } region_t;

    // One stage of the pin-timing delay line; hs/vs hold pin levels.
    typedef struct packed {
        logic hs;
        logic vs;
        logic act;
    } pin_tap_t;

    function automatic int unsigned axis_total(
        input int unsigned active_len,
        input int unsigned front_len,
        input int unsigned sync_len,
        input int unsigned back_len
    );
        return active_len + front_len + sync_len + back_len;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: a wrapping position counter plus its region FSM.
// Resets to the last position so the first step lands on 0 / ACTIVE.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int unsigned ACTIVE_LEN = DEF_H_ACTIVE,
    parameter int unsigned FRONT_LEN  = DEF_H_FRONT,
    parameter int unsigned SYNC_LEN   = DEF_H_SYNC,
    parameter int unsigned BACK_LEN   = DEF_H_BACK
) (
    input  logic               vga_clk,
    input  logic               vga_rst_n,
    input  logic               step,
    output logic [COORD_W-1:0] count,
    output region_t            region,
    output logic               wrap
);

    localparam int unsigned TOTAL = axis_total(ACTIVE_LEN, FRONT_LEN, SYNC_LEN, BACK_LEN);

    localparam logic [COORD_W-1:0] LAST     = COORD_W'(TOTAL - 1);
    localparam logic [COORD_W-1:0] FRONT_AT = COORD_W'(ACTIVE_LEN);
    localparam logic [COORD_W-1:0] SYNC_AT  = COORD_W'(ACTIVE_LEN + FRONT_LEN);
    localparam logic [COORD_W-1:0] BACK_AT  = COORD_W'(ACTIVE_LEN + FRONT_LEN + SYNC_LEN);

    logic [COORD_W-1:0] count_next;
    region_t            region_next;

    always_ff @(posedge vga_clk or negedge vga_rst_n) begin
        if (!vga_rst_n) begin
            count  <= LAST;
            region <= BACK;
        end else begin
            count  <= count_next;
            region <= region_next;
        end
    end

    // Region follows the count it will hold after this step, keeping both aligned.
    always_comb begin
        count_next  = count;
        region_next = region;
        if (step) begin
            count_next = (count == LAST) ? '0 : count + COORD_W'(1);
            unique case (region)
                ACTIVE: if (count_next == FRONT_AT) region_next = FRONT;
                FRONT:  if (count_next == SYNC_AT)  region_next = SYNC;
                SYNC:   if (count_next == BACK_AT)  region_next = BACK;
                BACK:   if (count_next == '0)       region_next = ACTIVE;
            endcase
        end
    end

    always_comb begin
        wrap = step && (count == LAST);
    end

endmodule

// File: rtl/vga_timing.sv
// Raster timing controller: coordinates out to the pixel generator,
// pipeline-aligned sync and blanked colour out to the VGA pins.
module vga_timing
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FRONT  = DEF_H_FRONT,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BACK   = DEF_H_BACK,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FRONT  = DEF_V_FRONT,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BACK   = DEF_V_BACK,
    parameter logic        HS_POL   = 1'b0,
    parameter logic        VS_POL   = 1'b0,
    parameter int unsigned PIPE     = DEF_PIPE
) (
    input  logic               vga_clk,
    input  logic               vga_rst_n,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               active,
    output logic               line_start,
    output logic               frame_start,
    output logic [15:0]        frame,
    input  logic [7:0]         rgb_in,
    output logic               vga_hs,
    output logic               vga_vs,
    output logic [7:0]         vga_rgb
);

    localparam int unsigned H_TOTAL = axis_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
    localparam int unsigned V_TOTAL = axis_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK);

    localparam pin_tap_t TAP_IDLE = '{hs: ~HS_POL, vs: ~VS_POL, act: 1'b0};

    if (H_TOTAL > MAX_TOTAL) begin : g_h_total_check
        $error("vga_timing: H_TOTAL %0d exceeds %0d", H_TOTAL, MAX_TOTAL);
    end
    if (V_TOTAL > MAX_TOTAL) begin : g_v_total_check
        $error("vga_timing: V_TOTAL %0d exceeds %0d", V_TOTAL, MAX_TOTAL);
    end
    if (PIPE > MAX_PIPE) begin : g_pipe_check
        $error("vga_timing: PIPE %0d exceeds %0d", PIPE, MAX_PIPE);
    end
    if (H_ACTIVE == 0 || H_FRONT == 0 || H_SYNC == 0 || H_BACK == 0 ||
        V_ACTIVE == 0 || V_FRONT == 0 || V_SYNC == 0 || V_BACK == 0) begin : g_len_check
        $error("vga_timing: every region length must be non-zero");
    end

    region_t  h_region;
    region_t  v_region;
    logic     h_wrap;
    logic     v_wrap;
    pin_tap_t tap_in;
    pin_tap_t tap_out;

    vga_axis_counter #(
        .ACTIVE_LEN (H_ACTIVE),
        .FRONT_LEN  (H_FRONT),
        .SYNC_LEN   (H_SYNC),
        .BACK_LEN   (H_BACK)
    ) u_h_axis (
        .vga_clk   (vga_clk),
        .vga_rst_n (vga_rst_n),
        .step      (1'b1),
        .count     (x),
        .region    (h_region),
        .wrap      (h_wrap)
    );

    // Stepping on the horizontal wrap keeps vsync edges on line boundaries.
    vga_axis_counter #(
        .ACTIVE_LEN (V_ACTIVE),
        .FRONT_LEN  (V_FRONT),
        .SYNC_LEN   (V_SYNC),
        .BACK_LEN   (V_BACK)
    ) u_v_axis (
        .vga_clk   (vga_clk),
        .vga_rst_n (vga_rst_n),
        .step      (h_wrap),
        .count     (y),
        .region    (v_region),
        .wrap      (v_wrap)
    );

    always_comb begin
        active      = (h_region == ACTIVE) && (v_region == ACTIVE);
        line_start  = (x == '0);
        frame_start = (x == '0) && (y == '0);
    end

    // Reset value 16'hFFFF so the first frame after release is numbered 0.
    always_ff @(posedge vga_clk or negedge vga_rst_n) begin
        if (!vga_rst_n) begin
            frame <= '1;
        end else if (h_wrap && v_wrap) begin
            frame <= frame + 16'd1;
        end
    end

    always_comb begin
        tap_in.hs  = (h_region == SYNC) ? HS_POL : ~HS_POL;
        tap_in.vs  = (v_region == SYNC) ? VS_POL : ~VS_POL;
        tap_in.act = active;
    end

    if (PIPE == 0) begin : g_no_delay
        assign tap_out = tap_in;
    end else begin : g_delay
        pin_tap_t stage [PIPE];

        always_ff @(posedge vga_clk or negedge vga_rst_n) begin
            if (!vga_rst_n) begin
                for (int unsigned i = 0; i < PIPE; i++) begin
                    stage[i] <= TAP_IDLE;
                end
            end else begin
                stage[0] <= tap_in;
                for (int unsigned i = 1; i < PIPE; i++) begin
                    stage[i] <= stage[i-1];
                end
            end
        end

        assign tap_out = stage[PIPE-1];
    end

    always_ff @(posedge vga_clk or negedge vga_rst_n) begin
        if (!vga_rst_n) begin
            vga_hs  <= ~HS_POL;
            vga_vs  <= ~VS_POL;
            vga_rgb <= '0;
        end else begin
            vga_hs  <= tap_out.hs;
            vga_vs  <= tap_out.vs;
            vga_rgb <= tap_out.act ? rgb_in : '0;
        end
    end

endmodule

// File: tb/tb_vga_timing.sv
// Scoreboard bench for vga_timing: three instances (full 640x480 with PIPE=2,
// plus two shrunken rasters with PIPE=0/7 and flipped polarities).
module tb_vga_timing;

    logic vga_clk   = 1'b0;
    logic vga_rst_n = 1'b1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 vga_clk = ~vga_clk;

    typedef struct packed {
        logic [9:0]  x;
        logic [9:0]  y;
        logic        active;
        logic        line_start;
        logic        frame_start;
        logic [15:0] frame;
        logic        hs;
        logic        vs;
        logic [7:0]  rgb;
    } obs_t;

    // Sync flags here mean "asserted", independent of pin polarity.
    typedef struct packed {
        logic hs;
        logic vs;
        logic act;
    } tap_t;

    function automatic string fmt(input obs_t o);
        return $sformatf("x=%0d y=%0d act=%0b ls=%0b fs=%0b frame=%0d hs=%0b vs=%0b rgb=%02h",
                         o.x, o.y, o.active, o.line_start, o.frame_start, o.frame,
                         o.hs, o.vs, o.rgb);
    endfunction

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        localparam bit          SMALL = (gi != 0);
        localparam int unsigned PIPE  = (gi == 0) ? 2 : (gi == 1) ? 0 : 7;
        localparam int unsigned HA    = SMALL ? 20 : 640;
        localparam int unsigned HF    = SMALL ? 3  : 16;
        localparam int unsigned HSW   = SMALL ? 5  : 96;
        localparam int unsigned HB    = SMALL ? 4  : 48;
        localparam int unsigned VA    = SMALL ? 12 : 480;
        localparam int unsigned VF    = SMALL ? 2  : 10;
        localparam int unsigned VSW   = SMALL ? 2  : 2;
        localparam int unsigned VB    = SMALL ? 3  : 33;
        localparam logic        HP    = (gi == 1);
        localparam logic        VP    = (gi == 2);
        localparam longint      HT    = HA + HF + HSW + HB;
        localparam longint      VT    = VA + VF + VSW + VB;

        logic [9:0]  x, y;
        logic        active, line_start, frame_start;
        logic [15:0] frame;
        logic [7:0]  rgb_in = 8'h00;
        logic        vga_hs, vga_vs;
        logic [7:0]  vga_rgb;

        vga_timing #(
            .H_ACTIVE (HA),
            .H_FRONT  (HF),
            .H_SYNC   (HSW),
            .H_BACK   (HB),
            .V_ACTIVE (VA),
            .V_FRONT  (VF),
            .V_SYNC   (VSW),
            .V_BACK   (VB),
            .HS_POL   (HP),
            .VS_POL   (VP),
            .PIPE     (PIPE)
        ) dut (
            .vga_clk     (vga_clk),
            .vga_rst_n   (vga_rst_n),
            .x           (x),
            .y           (y),
            .active      (active),
            .line_start  (line_start),
            .frame_start (frame_start),
            .frame       (frame),
            .rgb_in      (rgb_in),
            .vga_hs      (vga_hs),
            .vga_vs      (vga_vs),
            .vga_rgb     (vga_rgb)
        );

        obs_t   sb  [$];
        tap_t   dly [$];
        longint n = -1;

        function automatic obs_t reset_obs();
            obs_t o;
            o.x           = 10'(HT - 1);
            o.y           = 10'(VT - 1);
            o.active      = 1'b0;
            o.line_start  = 1'b0;
            o.frame_start = 1'b0;
            o.frame       = 16'hFFFF;
            o.hs          = ~HP;
            o.vs          = ~VP;
            o.rgb         = 8'h00;
            return o;
        endfunction

        function automatic obs_t sample();
            obs_t o;
            o.x           = x;
            o.y           = y;
            o.active      = active;
            o.line_start  = line_start;
            o.frame_start = frame_start;
            o.frame       = frame;
            o.hs          = vga_hs;
            o.vs          = vga_vs;
            o.rgb         = vga_rgb;
            return o;
        endfunction

        task automatic chk(input string tag, input obs_t got, input obs_t want);
            n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL %s dut%0d t=%0t got {%s} want {%s}",
                         tag, gi, $time, fmt(got), fmt(want));
            end
        endtask

        initial begin
            forever begin
                @(posedge vga_clk);
                #2;
                rgb_in = 8'($urandom);
            end
        end

        // Reference: position is simply the number of clocks since release.
        always @(posedge vga_clk) begin
            if (!vga_rst_n) begin
                n = -1;
                sb.delete();
                dly.delete();
                for (int k = 0; k <= int'(PIPE); k++) dly.push_back('0);
            end else begin
                longint xm, ym;
                tap_t   cur, old;
                obs_t   e;
                n++;
                xm      = n % HT;
                ym      = (n / HT) % VT;
                cur.hs  = (xm >= HA + HF) && (xm < HA + HF + HSW);
                cur.vs  = (ym >= VA + VF) && (ym < VA + VF + VSW);
                cur.act = (xm < HA) && (ym < VA);
                old     = dly.pop_front();
                dly.push_back(cur);
                e.x           = 10'(xm);
                e.y           = 10'(ym);
                e.active      = cur.act;
                e.line_start  = (xm == 0);
                e.frame_start = (xm == 0) && (ym == 0);
                e.frame       = 16'((n / (HT * VT)) % 65536);
                e.hs          = old.hs ? HP : ~HP;
                e.vs          = old.vs ? VP : ~VP;
                e.rgb         = old.act ? rgb_in : 8'h00;
                sb.push_back(e);
            end
        end

        always @(negedge vga_clk) begin
            if (!vga_rst_n) begin
                sb.delete();
                chk("reset_hold", sample(), reset_obs());
            end else if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sb_underflow dut%0d t=%0t got empty queue want entry", gi, $time);
            end else begin
                chk("raster", sample(), sb.pop_front());
            end
        end

        always @(negedge vga_rst_n) begin
            #1;
            chk("async_reset", sample(), reset_obs());
        end
    end

    initial begin
        #1 vga_rst_n = 1'b0;
        repeat (5) @(posedge vga_clk);
        @(negedge vga_clk);
        #1 vga_rst_n = 1'b1;

        repeat (2500) @(posedge vga_clk);

        for (int k = 0; k < 4; k++) begin
            repeat ($urandom_range(40, 2000)) @(posedge vga_clk);
            #($urandom_range(1, 4));
            vga_rst_n = 1'b0;
            repeat ($urandom_range(1, 3)) @(posedge vga_clk);
            @(negedge vga_clk);
            #1 vga_rst_n = 1'b1;
        end

        repeat (30000) @(posedge vga_clk);
        @(negedge vga_clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
